// File: rtl/barrel_unrotator_pkg.sv
// Shared constants and element-index helpers for the barrel shifter family.
// The unrotator and the existing barrel shifter both import this package.
package barrel_unrotator_pkg;

  localparam int DEFAULT_BIT_WIDTH = 8;
  localparam int DEFAULT_N         = 16;

  // Wraps any element index (including negative offsets) into 0..n-1.
  function automatic int elemMod(input int idx, input int n);
    int r;
    r = idx % n;
    if (r < 0) begin
      r = r + n;
    end
    return r;
  endfunction

endpackage

// File: rtl/barrel_unrotator_unrotate_stage.sv
// One combinational stage of the unrotator: rotates a word down by DIST elements
// when enabled, otherwise passes it straight through.
module unrotate_stage
  import barrel_unrotator_pkg::*;
#(
  parameter int BIT_WIDTH = DEFAULT_BIT_WIDTH,
  parameter int N         = DEFAULT_N,
  parameter int DIST      = 1
) (
  input  logic                   i_en,
  input  logic [BIT_WIDTH*N-1:0] i_data,
  output logic [BIT_WIDTH*N-1:0] o_data
);

  logic [BIT_WIDTH*N-1:0] w_rot;

  // Source indices are elaboration-time constants, so the wrap never goes out of range.
  for (genvar e = 0; e < N; e++) begin : g_elem
    localparam int SRC = elemMod(e + DIST, N);
    assign w_rot[e*BIT_WIDTH +: BIT_WIDTH] = i_data[SRC*BIT_WIDTH +: BIT_WIDTH];
  end

  assign o_data = i_en ? w_rot : i_data;

endmodule

// File: rtl/barrel_unrotator.sv
// Pipelined inverse of the barrel shifter: one log2(N)-deep register chain with a
// single global advance signal so a stalled output freezes the whole pipe.
module barrel_unrotator
  import barrel_unrotator_pkg::*;
#(
  parameter int BIT_WIDTH = DEFAULT_BIT_WIDTH,
  parameter int N         = DEFAULT_N
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BIT_WIDTH*N-1:0] IN,
  input  logic [$clog2(N)-1:0]   Shift,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BIT_WIDTH*N-1:0] OUT,
  output logic [$clog2(N)-1:0]   out_shift
);

  localparam int STAGES = $clog2(N);
  localparam int WORD_W = BIT_WIDTH * N;

  logic [WORD_W-1:0] r_data  [STAGES];
  logic [STAGES-1:0] r_shift [STAGES];
  logic [STAGES-1:0] r_valid;

  logic [WORD_W-1:0] w_stageIn  [STAGES];
  logic [WORD_W-1:0] w_stageOut [STAGES];
  logic [STAGES-1:0] w_stageEn;
  logic              w_advance;

  // Stage s consumes bit s of the shift that travels alongside its word.
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    if (s == 0) begin : g_first
      assign w_stageIn[s] = IN;
      assign w_stageEn[s] = Shift[0];
    end else begin : g_rest
      assign w_stageIn[s] = r_data[s-1];
      assign w_stageEn[s] = r_shift[s-1][s];
    end

    unrotate_stage #(
      .BIT_WIDTH(BIT_WIDTH),
      .N        (N),
      .DIST     (1 << s)
    ) u_stage (
      .i_en  (w_stageEn[s]),
      .i_data(w_stageIn[s]),
      .o_data(w_stageOut[s])
    );
  end

  assign w_advance = !r_valid[STAGES-1] || out_ready;

  // Bubbles enter stage 0 whenever the pipe moves without an input word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= '0;
      for (int s = 0; s < STAGES; s++) begin
        r_data[s]  <= '0;
        r_shift[s] <= '0;
      end
    end else if (w_advance) begin
      r_valid[0] <= in_valid;
      r_data[0]  <= w_stageOut[0];
      r_shift[0] <= Shift;
      for (int s = 1; s < STAGES; s++) begin
        r_valid[s] <= r_valid[s-1];
        r_data[s]  <= w_stageOut[s];
        r_shift[s] <= r_shift[s-1];
      end
    end
  end

  assign in_ready  = w_advance;
  assign out_valid = r_valid[STAGES-1];
  assign OUT       = r_data[STAGES-1];
  assign out_shift = r_shift[STAGES-1];

endmodule

// File: tb/tb_barrel_unrotator.sv
// Bench for barrel_unrotator: directed spot checks plus a randomized round trip
// through a behavioural left-rotating barrel shifter with a scoreboard.
module tb_barrel_unrotator;

  localparam int BW     = 8;
  localparam int N      = 16;
  localparam int STAGES = 4;
  localparam int WW     = BW * N;
  localparam int NUM_RANDOM = 10000;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [WW-1:0] IN;
  logic [3:0]    Shift;
  logic          out_valid;
  logic          out_ready;
  logic [WW-1:0] OUT;
  logic [3:0]    out_shift;

  int total = 0;
  int bad   = 0;

  logic [WW-1:0] expWord[$];
  logic [3:0]    expShift[$];

  barrel_unrotator #(.BIT_WIDTH(BW), .N(N)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .IN       (IN),
    .Shift    (Shift),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .OUT      (OUT),
    .out_shift(out_shift)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [WW-1:0] rampWord();
    logic [WW-1:0] w;
    for (int e = 0; e < N; e++) w[e*BW +: BW] = 8'(e);
    return w;
  endfunction

  function automatic logic [WW-1:0] randWord();
    logic [WW-1:0] w;
    for (int k = 0; k < WW / 32; k++) w[k*32 +: 32] = $urandom;
    return w;
  endfunction

  // What the existing barrel shifter produces: element j takes element (j - sh) mod N.
  function automatic logic [WW-1:0] rotLeft(input logic [WW-1:0] w, input int sh);
    logic [WW-1:0] r;
    for (int j = 0; j < N; j++) r[j*BW +: BW] = w[((j - sh + N) % N)*BW +: BW];
    return r;
  endfunction

  // Expected unrotation of the ramp word: element i holds value (i + sh) mod N.
  function automatic logic [WW-1:0] rampUnrot(input int sh);
    logic [WW-1:0] r;
    for (int i = 0; i < N; i++) r[i*BW +: BW] = 8'((i + sh) % N);
    return r;
  endfunction

  // Sends one word into an idle pipe and waits for it; lat counts edges from the accepting edge.
  task automatic runSingle(input logic [WW-1:0] word, input logic [3:0] sh,
                           output logic [WW-1:0] got, output logic [3:0] gotShift,
                           output int lat, output logic seen);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    IN        = word;
    Shift     = sh;
    @(posedge clk);
    lat = 1;
    #1;
    in_valid = 1'b0;
    IN       = randWord();
    Shift    = 4'($urandom);
    seen     = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
      else begin
        @(posedge clk);
        lat++;
      end
    end
    got      = OUT;
    gotShift = out_shift;
  endtask

  task automatic test_reset();
    reset_n   = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    IN        = randWord();
    Shift     = 4'd5;
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b want 0", out_valid); end
    total++;
    if (OUT !== '0) begin bad++; $display("[TB] FAIL reset_out: got %h want 0", OUT); end
    total++;
    if (out_shift !== 4'd0) begin bad++; $display("[TB] FAIL reset_shift: got %h want 0", out_shift); end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready: got %b want 1", in_ready); end
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_hold_valid: got %b want 0", out_valid); end
    in_valid = 1'b0;
    reset_n  = 1'b1;
  endtask

  task automatic test_identity();
    logic [WW-1:0] got;
    logic [3:0] gotShift;
    int lat;
    logic seen;
    runSingle(rampWord(), 4'd0, got, gotShift, lat, seen);
    total++;
    if (!seen) begin bad++; $display("[TB] FAIL identity_timeout: no out_valid after %0d edges", lat); end
    total++;
    if (lat !== STAGES) begin bad++; $display("[TB] FAIL identity_latency: got %0d want %0d", lat, STAGES); end
    total++;
    if (got !== rampWord()) begin bad++; $display("[TB] FAIL identity_out: got %h want %h", got, rampWord()); end
    total++;
    if (gotShift !== 4'd0) begin bad++; $display("[TB] FAIL identity_shift: got %0d want 0", gotShift); end
    @(posedge clk);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL identity_bubble: got %b want 0", out_valid); end
  endtask

  task automatic test_rotate();
    logic [WW-1:0] got;
    logic [3:0] gotShift;
    int lat;
    logic seen;
    runSingle(rampWord(), 4'd3, got, gotShift, lat, seen);
    total++;
    if (!seen || got[0*BW +: BW] !== 8'h03) begin bad++; $display("[TB] FAIL rotate_e0: got %h want 03", got[0*BW +: BW]); end
    total++;
    if (got[12*BW +: BW] !== 8'h0F) begin bad++; $display("[TB] FAIL rotate_e12: got %h want 0f", got[12*BW +: BW]); end
    total++;
    if (got[13*BW +: BW] !== 8'h00) begin bad++; $display("[TB] FAIL rotate_e13: got %h want 00", got[13*BW +: BW]); end
    total++;
    if (got[15*BW +: BW] !== 8'h02) begin bad++; $display("[TB] FAIL rotate_e15: got %h want 02", got[15*BW +: BW]); end
    total++;
    if (got !== rampUnrot(3)) begin bad++; $display("[TB] FAIL rotate_word: got %h want %h", got, rampUnrot(3)); end
    total++;
    if (gotShift !== 4'd3) begin bad++; $display("[TB] FAIL rotate_shift: got %0d want 3", gotShift); end
  endtask

  task automatic test_boundary();
    logic [WW-1:0] got;
    logic [3:0] gotShift;
    int lat;
    logic seen;
    runSingle(rampWord(), 4'd15, got, gotShift, lat, seen);
    total++;
    if (!seen || got[0*BW +: BW] !== 8'h0F) begin bad++; $display("[TB] FAIL boundary_e0: got %h want 0f", got[0*BW +: BW]); end
    total++;
    if (got[1*BW +: BW] !== 8'h00) begin bad++; $display("[TB] FAIL boundary_e1: got %h want 00", got[1*BW +: BW]); end
    total++;
    if (got !== rampUnrot(15)) begin bad++; $display("[TB] FAIL boundary_word: got %h want %h", got, rampUnrot(15)); end
    total++;
    if (gotShift !== 4'd15) begin bad++; $display("[TB] FAIL boundary_shift: got %0d want 15", gotShift); end
  endtask

  task automatic test_roundtrip();
    int sent = 0;
    int cycles = 0;
    logic [WW-1:0] orig;
    logic [3:0] sh;
    expWord.delete();
    expShift.delete();
    while ((sent < NUM_RANDOM || expWord.size() != 0) && cycles < 60000) begin
      @(negedge clk);
      cycles++;
      out_ready = ($urandom_range(0, 4) != 0);
      in_valid  = (sent < NUM_RANDOM) && ($urandom_range(0, 9) != 0);
      orig      = randWord();
      sh        = 4'($urandom);
      IN        = rotLeft(orig, int'(sh));
      Shift     = sh;
      #1;
      total++;
      if (in_ready !== (!out_valid || out_ready)) begin
        bad++;
        $display("[TB] FAIL roundtrip_ready: got %b want %b", in_ready, (!out_valid || out_ready));
      end
      if (out_valid && out_ready) begin
        total++;
        if (expWord.size() == 0) begin
          bad++;
          $display("[TB] FAIL roundtrip_extra: got %h want no word", OUT);
        end else begin
          if (OUT !== expWord[0] || out_shift !== expShift[0]) begin
            bad++;
            $display("[TB] FAIL roundtrip_word: got %h/%0d want %h/%0d", OUT, out_shift, expWord[0], expShift[0]);
          end
          void'(expWord.pop_front());
          void'(expShift.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        expWord.push_back(orig);
        expShift.push_back(sh);
        sent++;
      end
    end
    total++;
    if (expWord.size() != 0 || sent != NUM_RANDOM) begin
      bad++;
      $display("[TB] FAIL roundtrip_drain: got sent=%0d left=%0d want sent=%0d left=0", sent, expWord.size(), NUM_RANDOM);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_backpressure();
    logic [WW-1:0] orig;
    logic [WW-1:0] held;
    logic [3:0] sh;
    int guard;
    expWord.delete();
    expShift.delete();
    // Fill phase with simultaneous emit and accept once the pipe is full.
    for (int c = 0; c < 6 + 5 + 40; c++) begin
      @(negedge clk);
      if (c < 6) begin
        out_ready = 1'b1;
        in_valid  = 1'b1;
      end else if (c < 11) begin
        out_ready = 1'b0;
        in_valid  = 1'b1;
      end else begin
        out_ready = 1'b1;
        in_valid  = 1'b0;
      end
      orig  = randWord();
      sh    = 4'($urandom);
      IN    = rotLeft(orig, int'(sh));
      Shift = sh;
      #1;
      if (c == 6) held = OUT;
      if (c >= 6 && c < 11) begin
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
          bad++;
          $display("[TB] FAIL bp_stall: got ready=%b valid=%b want ready=0 valid=1", in_ready, out_valid);
        end
        total++;
        if (OUT !== held) begin bad++; $display("[TB] FAIL bp_stable: got %h want %h", OUT, held); end
      end
      if (out_valid && out_ready) begin
        total++;
        if (expWord.size() == 0) begin
          bad++;
          $display("[TB] FAIL bp_duplicate: got %h want no word", OUT);
        end else begin
          if (OUT !== expWord[0] || out_shift !== expShift[0]) begin
            bad++;
            $display("[TB] FAIL bp_order: got %h/%0d want %h/%0d", OUT, out_shift, expWord[0], expShift[0]);
          end
          void'(expWord.pop_front());
          void'(expShift.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        expWord.push_back(orig);
        expShift.push_back(sh);
      end
      guard = c;
    end
    total++;
    if (expWord.size() != 0) begin
      bad++;
      $display("[TB] FAIL bp_lost: got %0d words left after %0d cycles want 0", expWord.size(), guard);
    end
  endtask

  task automatic test_reset_midstream();
    logic [WW-1:0] fresh;
    logic [WW-1:0] orig;
    logic [3:0] sh;
    int lat;
    logic seen;
    out_ready = 1'b0;
    for (int w = 0; w < 4; w++) begin
      @(negedge clk);
      orig     = randWord();
      in_valid = 1'b1;
      IN       = rotLeft(orig, w + 1);
      Shift    = 4'(w + 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL midreset_pre_valid: got %b want 1", out_valid); end
    #1;
    reset_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL midreset_valid: got %b want 0", out_valid); end
    total++;
    if (OUT !== '0 || out_shift !== 4'd0) begin
      bad++;
      $display("[TB] FAIL midreset_out: got %h/%0d want 0/0", OUT, out_shift);
    end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL midreset_ready: got %b want 1", in_ready); end
    @(negedge clk);
    reset_n = 1'b1;
    fresh = randWord();
    sh    = 4'($urandom);
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    IN       = rotLeft(fresh, int'(sh));
    Shift    = sh;
    @(posedge clk);
    lat = 1;
    #1;
    in_valid = 1'b0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
      else begin
        @(posedge clk);
        lat++;
      end
    end
    total++;
    if (!seen || lat !== STAGES) begin
      bad++;
      $display("[TB] FAIL midreset_latency: got seen=%b lat=%0d want lat=%0d", seen, lat, STAGES);
    end
    total++;
    if (OUT !== fresh || out_shift !== sh) begin
      bad++;
      $display("[TB] FAIL midreset_first: got %h/%0d want %h/%0d", OUT, out_shift, fresh, sh);
    end
    @(posedge clk);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL midreset_stale: got %b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_rotate();
    test_boundary();
    test_backpressure();
    test_reset_midstream();
    test_roundtrip();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
